// File: rtl/date_pkg.sv
// Shared types and helpers for the date-setting controller: FSM state
// encoding, default year window, calendar lookup and BCD conversions.
package date_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SET_YEAR  = 3'd1,
    ST_SET_MONTH = 3'd2,
    ST_SET_DAY   = 3'd3,
    ST_COMMIT    = 3'd4
  } state_e;

  localparam int YEAR_MIN_DEF = 21;
  localparam int YEAR_MAX_DEF = 48;

  // Month length; within 21..48 every year divisible by 4 is a leap year.
  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [5:0] year);
    logic [4:0] md;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: md = 5'd30;
      4'd2:                    md = ((year % 6'd4) == 6'd0) ? 5'd29 : 5'd28;
      default:                 md = 5'd31;
    endcase
    return md;
  endfunction

  // Two-digit binary (0..99) to packed BCD {tens, ones}.
  function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Packed two-digit BCD to binary.
  function automatic logic [6:0] bcd2bin2(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, tick-sampled debounce
// that needs DEB_TICKS consecutive opposite samples to flip, and a
// one-clock press pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_raw_i,
  output logic press_o
);
  localparam int CW = $clog2(DEB_TICKS + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d, level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive ticks that disagree with the current level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(DEB_TICKS - 1)) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Synchroniser, debounce state and edge-detect history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= 2'b00;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], btn_raw_i};
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/date_set_ctrl.sv
// Date edit controller: pauses the date counter, lets the user step the
// year, month and day with mode/inc/dec, and issues a one-clock load
// strobe with the packed BCD working date on commit.
module date_set_ctrl
  import date_pkg::*;
#(
  parameter int DEB_TICKS = 4,
  parameter int YEAR_MIN  = YEAR_MIN_DEF,
  parameter int YEAR_MAX  = YEAR_MAX_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        btn_mode_i,
  input  logic        btn_inc_i,
  input  logic        btn_dec_i,
  input  logic [23:0] cur_date_i,
  output logic [23:0] set_date_o,
  output logic        load_o,
  output logic        editing_o,
  output logic [1:0]  edit_field_o
);
  localparam logic [5:0] YMIN = 6'(YEAR_MIN);
  localparam logic [5:0] YMAX = 6'(YEAR_MAX);

  logic [2:0] raw_btn;
  logic [2:0] press;
  logic       mode_p, inc_p, dec_p;

  state_e     state_q, state_d;
  logic [5:0] year_q, year_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d;
  logic [4:0] max_cur;

  assign raw_btn = {btn_dec_i, btn_inc_i, btn_mode_i};

  // One debouncer per button: bit 0 mode, bit 1 inc, bit 2 dec.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (tick_i),
      .btn_raw_i (raw_btn[gi]),
      .press_o   (press[gi])
    );
  end

  // Mode overrides everything; inc together with dec cancels out.
  assign mode_p = press[0];
  assign inc_p  = press[1] & ~press[2] & ~press[0];
  assign dec_p  = press[2] & ~press[1] & ~press[0];

  assign max_cur = days_in_month(month_q, year_q);

  // Next state and field arithmetic, with day clamped after year/month edits.
  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_p) begin
          year_d  = 6'(bcd2bin2(cur_date_i[23:16]));
          month_d = 4'(bcd2bin2(cur_date_i[15:8]));
          day_d   = 5'(bcd2bin2(cur_date_i[7:0]));
          state_d = ST_SET_YEAR;
        end
      end
      ST_SET_YEAR: begin
        if (mode_p)     state_d = ST_SET_MONTH;
        else if (inc_p) year_d  = (year_q >= YMAX) ? YMIN : year_q + 6'd1;
        else if (dec_p) year_d  = (year_q <= YMIN) ? YMAX : year_q - 6'd1;
      end
      ST_SET_MONTH: begin
        if (mode_p)     state_d = ST_SET_DAY;
        else if (inc_p) month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
        else if (dec_p) month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
      end
      ST_SET_DAY: begin
        if (mode_p)     state_d = ST_COMMIT;
        else if (inc_p) day_d   = (day_q >= max_cur) ? 5'd1 : day_q + 5'd1;
        else if (dec_p) day_d   = (day_q <= 5'd1) ? max_cur : day_q - 5'd1;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if ((state_q == ST_SET_YEAR || state_q == ST_SET_MONTH) &&
        day_q > days_in_month(month_d, year_d)) begin
      day_d = days_in_month(month_d, year_d);
    end
  end

  // State and working-date registers; reset discards any edit in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      year_q  <= YMIN;
      month_q <= 4'd1;
      day_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
    end
  end

  // Outputs decoded from the state register only, so load cannot glitch.
  always_comb begin
    load_o       = 1'b0;
    editing_o    = 1'b0;
    edit_field_o = 2'b00;
    case (state_q)
      ST_SET_YEAR:  begin editing_o = 1'b1; edit_field_o = 2'b01; end
      ST_SET_MONTH: begin editing_o = 1'b1; edit_field_o = 2'b10; end
      ST_SET_DAY:   begin editing_o = 1'b1; edit_field_o = 2'b11; end
      ST_COMMIT:    load_o = 1'b1;
      default:      ;
    endcase
  end

  assign set_date_o = {bin2bcd2(7'(year_q)), bin2bcd2(7'(month_q)),
                       bin2bcd2(7'(day_q))};

endmodule

// File: tb/tb_date_set_ctrl.sv
// Scoreboard bench for date_set_ctrl: stimulus drives buttons and pushes
// expected {set_date, editing, edit_field} changes and load dates; a
// monitor pops and compares whenever the DUT outputs change or load fires.
module tb_date_set_ctrl;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        b_mode = 1'b0, b_inc = 1'b0, b_dec = 1'b0;
  logic [23:0] cur_date = 24'h210101;
  logic [23:0] set_date;
  logic        load, editing;
  logic [1:0]  edit_field;

  int total = 0;
  int bad   = 0;

  logic [26:0] exp_q[$];
  logic [23:0] load_q[$];
  logic [26:0] prev_t;
  bit          mon_en = 1'b0;

  // Reference model: edit phase (0 idle, 1 year, 2 month, 3 day) and date.
  int          m_st = 0, m_y = 21, m_mo = 1, m_d = 1;
  logic [26:0] m_tuple;

  date_set_ctrl #(.DEB_TICKS(DEB)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tick_i       (tick),
    .btn_mode_i   (b_mode),
    .btn_inc_i    (b_inc),
    .btn_dec_i    (b_dec),
    .cur_date_i   (cur_date),
    .set_date_o   (set_date),
    .load_o       (load),
    .editing_o    (editing),
    .edit_field_o (edit_field)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int mdays(int mo, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && (y % 4) == 0) return 29;
    return t[mo-1];
  endfunction

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int unbcd(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [26:0] model_tuple();
    logic ed;
    ed = (m_st >= 1 && m_st <= 3);
    return {bcd(m_y), bcd(m_mo), bcd(m_d), ed, ed ? 2'(m_st) : 2'b00};
  endfunction

  task automatic chk(string name, logic [26:0] act, logic [26:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_if_changed();
    logic [26:0] nt;
    nt = model_tuple();
    if (nt != m_tuple) exp_q.push_back(nt);
    m_tuple = nt;
  endtask

  // Apply one arbitrated press to the model at the level of calendar rules.
  task automatic model_press(bit m, bit i, bit d);
    int dl;
    if (m) begin
      case (m_st)
        0: begin
          m_y  = unbcd(cur_date[23:16]);
          m_mo = unbcd(cur_date[15:8]);
          m_d  = unbcd(cur_date[7:0]);
          m_st = 1;
        end
        1: m_st = 2;
        2: m_st = 3;
        default: begin
          m_st = 0;
          load_q.push_back({bcd(m_y), bcd(m_mo), bcd(m_d)});
        end
      endcase
    end else if (i != d && m_st != 0) begin
      dl = i ? 1 : -1;
      case (m_st)
        1: m_y  = 21 + ((m_y - 21 + dl + 28) % 28);
        2: m_mo = 1 + ((m_mo - 1 + dl + 12) % 12);
        default: m_d = 1 + ((m_d - 1 + dl + mdays(m_mo, m_y)) % mdays(m_mo, m_y));
      endcase
      if (m_d > mdays(m_mo, m_y)) m_d = mdays(m_mo, m_y);
    end
    push_if_changed();
  endtask

  task automatic run_ticks(int n);
    repeat (n) begin
      repeat (2) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  task automatic press(bit m, bit i, bit d);
    model_press(m, i, d);
    $display("txn press mode=%0d inc=%0d dec=%0d cur=%h expect=%h", m, i, d, cur_date, m_tuple);
    b_mode = m; b_inc = i; b_dec = d;
    run_ticks(DEB + 2);
    b_mode = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
    run_ticks(DEB + 2);
  endtask

  task automatic goto_idle();
    while (m_st != 0) press(1, 0, 0);
  endtask

  // Bounce 1-0-1 then stable high: a single increment.
  task automatic bounce_inc();
    model_press(0, 1, 0);
    $display("txn bounce inc expect=%h", m_tuple);
    b_inc = 1'b1; run_ticks(1);
    b_inc = 1'b0; run_ticks(1);
    b_inc = 1'b1; run_ticks(DEB + 1);
    b_inc = 1'b0; run_ticks(DEB + 2);
  endtask

  // Too-short pulse: no change expected.
  task automatic glitch_inc();
    $display("txn glitch inc expect=%h", m_tuple);
    b_inc = 1'b1; run_ticks(DEB - 1);
    b_inc = 1'b0; run_ticks(DEB + 2);
  endtask

  task automatic pulse_reset();
    m_st = 0; m_y = 21; m_mo = 1; m_d = 1;
    push_if_changed();
    $display("txn reset expect=%h", m_tuple);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_ticks(2);
  endtask

  task automatic rand_cur();
    int y, mo, d;
    y  = $urandom_range(48, 21);
    mo = $urandom_range(12, 1);
    d  = $urandom_range(mdays(mo, y), 1);
    cur_date = {bcd(y), bcd(mo), bcd(d)};
  endtask

  // Monitor: every output change must match the next expected tuple, and
  // every load must match the next expected committed date.
  always @(negedge clk) begin
    logic [26:0] cur_t;
    logic [26:0] e;
    if (mon_en) begin
      cur_t = {set_date, editing, edit_field};
      if (cur_t !== prev_t) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_change: got %h want %h", cur_t, prev_t);
        end else begin
          e = exp_q.pop_front();
          chk("state_tuple", cur_t, e);
        end
        prev_t = cur_t;
      end
      if (load === 1'b1) begin
        if (load_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load: got load=1 date=%h want load=0", set_date);
        end else begin
          chk("load_date", 27'(set_date), 27'(load_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tuple", {set_date, editing, edit_field}, {24'h210101, 1'b0, 2'b00});
    chk("reset_load", 27'(load), 27'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_tuple = model_tuple();
    prev_t  = {set_date, editing, edit_field};
    mon_en  = 1'b1;

    // inc/dec in idle are ignored
    press(0, 1, 0);
    press(0, 0, 1);

    // full edit with leap clamp 31 -> 29
    cur_date = 24'h230131;
    press(1, 0, 0); press(0, 1, 0);
    press(1, 0, 0); press(0, 1, 0);
    press(1, 0, 0); press(1, 0, 0);

    // non-leap clamp then day wrap
    cur_date = 24'h240229;
    press(1, 0, 0); press(0, 1, 0);
    press(1, 0, 0); press(1, 0, 0);
    press(0, 1, 0);
    goto_idle();

    // year and month wraps in both directions
    cur_date = 24'h481215;
    press(1, 0, 0); press(0, 1, 0); press(0, 0, 1);
    press(1, 0, 0); press(0, 1, 0); press(0, 0, 1);
    goto_idle();

    // simultaneous presses, bounce and glitch
    cur_date = 24'h300305;
    press(1, 0, 0);
    press(1, 1, 0);
    press(1, 0, 0);
    press(0, 1, 1);
    bounce_inc();
    glitch_inc();
    goto_idle();

    // reset in the middle of month editing
    cur_date = 24'h330815;
    press(1, 0, 0); press(1, 0, 0);
    pulse_reset();

    // randomized sequence
    repeat (80) begin
      if (m_st == 0) rand_cur();
      r = $urandom_range(9);
      case (r)
        0, 1, 2: press(1, 0, 0);
        3, 4:    press(0, 1, 0);
        5, 6:    press(0, 0, 1);
        7:       press(0, 1, 1);
        8:       press(1, 1, 0);
        default: press(1, 0, 1);
      endcase
    end
    goto_idle();

    repeat (50) @(posedge clk);
    #1;
    chk("tuple_queue_drained", 27'(exp_q.size()), 27'd0);
    chk("load_queue_drained", 27'(load_q.size()), 27'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
